// File: rtl/muldiv_pkg.sv
// Shared encodings and op-class helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // MULT/MULTU/DIV/DIVU all sit in the lower half of the encoding space
  function automatic logic is_muldiv(input logic [2:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate used for operand magnitude and result sign fix-up.
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  assign q = neg ? (~d + WIDTH'(1)) : d;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO registers and abort.
// Optional MULDIV_EARLY_TERM_EN: multiplies finish once remaining multiplier bits are zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef MULDIV_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  md_state_e          state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mb;
  logic               div_op, neg_res, neg_rem, b_zero;

  logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic               go, mthi_go, mtlo_go, last;
  logic [WIDTH:0]     rs, diff;
  logic               ge;

  assign go      = start && !abort && is_muldiv(op);
  assign mthi_go = start && !abort && (op == MD_MTHI);
  assign mtlo_go = start && !abort && (op == MD_MTLO);
  assign busy    = (state != S_IDLE);

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (
    .neg(is_signed(op) && a[WIDTH-1]), .d(a), .q(a_abs));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (
    .neg(is_signed(op) && b[WIDTH-1]), .d(b), .q(b_abs));
  muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
    .neg(neg_res), .d(acc), .q(prod_fix));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_quo (
    .neg(neg_res), .d(acc[WIDTH-1:0]), .q(quo_fix));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .neg(neg_rem), .d(acc[2*WIDTH-1:WIDTH]), .q(rem_fix));

  // Restoring-divide trial: acc holds {remainder, remaining dividend bits / quotient}
  assign rs   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff = rs - {1'b0, mb};
  assign ge   = !diff[WIDTH];

  always_comb begin
    last     = (cnt == '0);
    state_nx = state;
    if (EARLY_TERM && !div_op && (mb[WIDTH-1:1] == '0))
      last = 1'b1;
    case (state)
      S_IDLE:  if (go) state_nx = S_RUN;
      S_RUN:   if (abort) state_nx = S_IDLE;
               else if (last) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mb       <= '0;
      div_op   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      b_zero   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            cnt      <= CNT_W'(WIDTH - 1);
            div_op   <= is_div(op);
            neg_res  <= is_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= is_signed(op) && a[WIDTH-1];
            b_zero   <= (b == '0);
            div_zero <= 1'b0;
            mb       <= b_abs;
            mcand    <= {{WIDTH{1'b0}}, a_abs};
            acc      <= is_div(op) ? {{WIDTH{1'b0}}, a_abs} : '0;
          end else if (mthi_go) begin
            hi <= a;
          end else if (mtlo_go) begin
            lo <= a;
          end
        end
        S_RUN: begin
          cnt <= cnt - 1'b1;
          if (div_op) begin
            acc <= {(ge ? diff[WIDTH-1:0] : rs[WIDTH-1:0]), acc[WIDTH-2:0], ge};
          end else begin
            if (mb[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            mb    <= mb >> 1;
          end
        end
        S_FIX: begin
          if (!abort) begin
            done <= 1'b1;
            if (div_op) begin
              hi       <= rem_fix;
              lo       <= b_zero ? {WIDTH{1'b1}} : quo_fix;
              div_zero <= b_zero;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
